// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared types and defaults for the SRAM read sequencer
//
// Purpose: state encoding, default parameter values and the counter-width
// helper used by sram_read_seq and sram_wl_decoder.
// Ports: none (package).
// Configuration macro: SRAM_READ_CHECK_EN (consumed by sram_read_seq).

package sram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    SEL  = 2'd2,
    RESP = 2'd3
  } sram_rd_state_e;

  localparam int SRAM_WIDTH_DEF   = 8;
  localparam int SRAM_ADDR_W_DEF  = 4;
  localparam int SRAM_PRE_CYC_DEF = 2;
  localparam int SRAM_WL_CYC_DEF  = 2;

  // Width of a down-counter that must hold max(a,b)-1, with one bit of slack.
  function automatic int sram_cnt_w(input int a, input int b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

endpackage

// File: rtl/sram_wl_decoder.sv
// rtl/sram_wl_decoder.sv - row address to one-hot wordline decoder with enable
//
// Purpose: combinational ADDR_W -> 2**ADDR_W one-hot decode; all-zero output
// when the enable is low.
// Ports:
//   i_en    in   1       decode enable
//   i_addr  in   ADDR_W  row address
//   o_wl    out  ROWS    one-hot wordline pattern

module sram_wl_decoder
  import sram_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_W_DEF,
  parameter int ROWS   = 2 ** ADDR_W
) (
  input  logic              i_en,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [ROWS-1:0]   o_wl
);

  always_comb begin
    o_wl = '0;
    if (i_en) begin
      o_wl[i_addr] = 1'b1;
    end
  end

endmodule

// File: rtl/sram_read_seq.sv
// rtl/sram_read_seq.sv - SRAM row read sequencer (precharge, wordline, sense)
//
// Purpose: accepts a row address on a valid/ready request channel, precharges
// the bitlines, drives the one-hot wordline of the latched row, samples the
// differential bitline pairs and returns the word on a valid/ready response
// channel.
// Ports:
//   clk        in   1       rising-edge clock
//   rst_n      in   1       synchronous active-low reset
//   req_valid  in   1       read request
//   req_ready  out  1       request accepted on req_valid && req_ready
//   req_addr   in   ADDR_W  row to read
//   pre        out  1       bitline precharge enable
//   wl         out  ROWS    one-hot wordline, zero when not selecting
//   bl         in   WIDTH   true bitlines
//   blb        in   WIDTH   complement bitlines
//   rsp_valid  out  1       response valid
//   rsp_ready  in   1       response consumed on rsp_valid && rsp_ready
//   rsp_data   out  WIDTH   sensed word
//   rsp_err    out  1       sense error (some pair not differential)
// Configuration macro: SRAM_READ_CHECK_EN - when defined rsp_err reports
// non-differential bitline pairs; when undefined rsp_err is 0 and blb unused.

module sram_read_seq
  import sram_pkg::*;
#(
  parameter int WIDTH   = SRAM_WIDTH_DEF,
  parameter int ADDR_W  = SRAM_ADDR_W_DEF,
  parameter int PRE_CYC = SRAM_PRE_CYC_DEF,
  parameter int WL_CYC  = SRAM_WL_CYC_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ADDR_W-1:0]      req_addr,
  output logic                   pre,
  output logic [(2**ADDR_W)-1:0] wl,
  input  logic [WIDTH-1:0]       bl,
  input  logic [WIDTH-1:0]       blb,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_data,
  output logic                   rsp_err
);

  localparam int ROWS  = 2 ** ADDR_W;
  localparam int CNT_W = sram_cnt_w(PRE_CYC, WL_CYC);

  // Counter is loaded with (hold cycles - 1) on entry and the state exits on 0.
  localparam logic [CNT_W-1:0] PRE_LOAD = CNT_W'(PRE_CYC - 1);
  localparam logic [CNT_W-1:0] WL_LOAD  = CNT_W'(WL_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  sram_rd_state_e    r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_pre;
  logic [ROWS-1:0]   r_wl;
  logic              r_rsp_valid;
  logic [WIDTH-1:0]  r_rsp_data;
  logic              r_rsp_err;

  logic              w_req_ready;
  logic              w_sel_next;
  logic              w_sense_err;
  logic [ROWS-1:0]   w_wl_dec;

  assign w_req_ready = (r_state == IDLE) || ((r_state == RESP) && rsp_ready);

  // The decoder output is registered, so it is enabled for the cycles whose
  // following edge lands in (or stays in) SEL; the wordline register is then
  // high exactly while the state register holds SEL.
  assign w_sel_next = ((r_state == PRE) && (r_cnt == '0)) ||
                      ((r_state == SEL) && (r_cnt != '0));

  sram_wl_decoder #(
    .ADDR_W (ADDR_W),
    .ROWS   (ROWS)
  ) u_wl_dec (
    .i_en   (w_sel_next),
    .i_addr (r_addr),
    .o_wl   (w_wl_dec)
  );

`ifdef SRAM_READ_CHECK_EN
  // XNOR is 1 where true and complement agree, i.e. the pair did not split.
  assign w_sense_err = |(bl ~^ blb);
`else
  logic w_unused_blb;
  assign w_unused_blb = ^blb;
  assign w_sense_err  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_pre       <= 1'b0;
      r_wl        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_wl <= w_wl_dec;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_state <= PRE;
            r_cnt   <= PRE_LOAD;
            r_addr  <= req_addr;
            r_pre   <= 1'b1;
          end
        end
        PRE: begin
          if (r_cnt == '0) begin
            r_state <= SEL;
            r_cnt   <= WL_LOAD;
            r_pre   <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        SEL: begin
          if (r_cnt == '0) begin
            r_state     <= RESP;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= bl;
            r_rsp_err   <= w_sense_err;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        RESP: begin
          // Data/err registers are only written on SEL exit, so they hold
          // steady for as long as the consumer stalls.
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            if (req_valid) begin
              r_state <= PRE;
              r_cnt   <= PRE_LOAD;
              r_addr  <= req_addr;
              r_pre   <= 1'b1;
            end else begin
              r_state <= IDLE;
              r_cnt   <= '0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign req_ready = w_req_ready;
  assign pre       = r_pre;
  assign wl        = r_wl;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_sram_read_seq.sv
// tb/tb_sram_read_seq.sv - self-checking bench for sram_read_seq

module tb_sram_read_seq;

  localparam int W    = 8;
  localparam int AW   = 4;
  localparam int ROWS = 16;

`ifdef SRAM_READ_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic            req_valid, req_ready, pre, rsp_valid, rsp_ready, rsp_err;
  logic [AW-1:0]   req_addr;
  logic [ROWS-1:0] wl;
  logic [W-1:0]    bl, blb, rsp_data;

  logic            req_valid2, req_ready2, pre2, rsp_valid2, rsp_ready2, rsp_err2;
  logic [AW-1:0]   req_addr2;
  logic [ROWS-1:0] wl2;
  logic [W-1:0]    bl2, blb2, rsp_data2;

  sram_read_seq u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .pre(pre), .wl(wl), .bl(bl), .blb(blb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  sram_read_seq #(.PRE_CYC(1), .WL_CYC(3)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid2), .req_ready(req_ready2), .req_addr(req_addr2),
    .pre(pre2), .wl(wl2), .bl(bl2), .blb(blb2),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2), .rsp_data(rsp_data2), .rsp_err(rsp_err2)
  );

  // Cell array model: selected row drives its word differentially, or
  // non-differentially when force_err is set; idle lines float at idle_bl.
  logic [W-1:0] mem [ROWS];
  logic [W-1:0] idle_bl;
  logic         force_err;

  always_comb begin
    bl  = idle_bl;
    blb = ~idle_bl;
    for (int r = 0; r < ROWS; r++) begin
      if (wl[r]) begin
        bl  = mem[r];
        blb = force_err ? mem[r] : ~mem[r];
      end
    end
  end

  always_comb begin
    bl2  = idle_bl;
    blb2 = ~idle_bl;
    for (int r = 0; r < ROWS; r++) begin
      if (wl2[r]) begin
        bl2  = mem[r];
        blb2 = force_err ? mem[r] : ~mem[r];
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  logic [W:0] sb1 [$];
  logic [W:0] sb2 [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      n_tests++;
      assert (!(pre && (|wl)) && !(pre2 && (|wl2))) else begin
        n_fail++;
        $error("FAIL pre_wl_overlap: observed pre=%b wl=%h pre2=%b wl2=%h expected no overlap",
               pre, wl, pre2, wl2);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at the negedge of cycle 0 (after the accept edge).
  task automatic accept1(input logic [AW-1:0] a);
    int k;
    k = 0;
    req_addr  = a;
    req_valid = 1'b1;
    #1;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("accept1_bound", 32'(k < 20), 1);
    sb1.push_back({force_err & CHK, mem[a]});
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic accept2(input logic [AW-1:0] a);
    int k;
    k = 0;
    req_addr2  = a;
    req_valid2 = 1'b1;
    #1;
    while (!req_ready2 && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("accept2_bound", 32'(k < 20), 1);
    sb2.push_back({force_err & CHK, mem[a]});
    @(negedge clk);
    req_valid2 = 1'b0;
  endtask

  task automatic wait_rsp1(input string tag, input int start, input int exp_lat);
    int k;
    k = start;
    while (!rsp_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    check($sformatf("%s_lat", tag), k, exp_lat);
  endtask

  task automatic pop1(input string tag);
    logic [W:0] e;
    check($sformatf("%s_sb_nonempty", tag), 32'(sb1.size() > 0), 1);
    if (sb1.size() > 0) begin
      e = sb1.pop_front();
      check($sformatf("%s_data", tag), 32'(rsp_data), 32'(e[W-1:0]));
      check($sformatf("%s_err", tag), 32'(rsp_err), 32'(e[W]));
    end
  endtask

  task automatic pop2(input string tag);
    logic [W:0] e;
    check($sformatf("%s_sb_nonempty", tag), 32'(sb2.size() > 0), 1);
    if (sb2.size() > 0) begin
      e = sb2.pop_front();
      check($sformatf("%s_data", tag), 32'(rsp_data2), 32'(e[W-1:0]));
      check($sformatf("%s_err", tag), 32'(rsp_err2), 32'(e[W]));
    end
  endtask

  initial begin
    logic saw;
    rst_n = 1'b0;
    req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
    req_valid2 = 1'b0; req_addr2 = '0; rsp_ready2 = 1'b0;
    idle_bl = 8'h00; force_err = 1'b0;
    for (int r = 0; r < ROWS; r++) mem[r] = 8'(r * 17 + 3);
    mem[5] = 8'hA5; mem[0] = 8'h3C; mem[15] = 8'hC3; mem[3] = 8'h69; mem[9] = 8'h01;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_pre", 32'(pre), 0);
    check("rst_wl", 32'(wl), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_data", 32'(rsp_data), 0);
    check("rst_rsp_err", 32'(rsp_err), 0);
    check("rst_req_ready", 32'(req_ready), 1);
    check("rst2_pre", 32'(pre2), 0);
    check("rst2_wl", 32'(wl2), 0);
    check("rst2_rsp_valid", 32'(rsp_valid2), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single read of row 5, rsp_ready held low
    accept1(4'd5);
    check("rd_c0_pre", 32'(pre), 1);
    check("rd_c0_wl", 32'(wl), 0);
    @(negedge clk);
    check("rd_c1_pre", 32'(pre), 1);
    check("rd_c1_wl", 32'(wl), 0);
    @(negedge clk);
    check("rd_c2_pre", 32'(pre), 0);
    check("rd_c2_wl", 32'(wl), 32'h0020);
    check("rd_c2_valid", 32'(rsp_valid), 0);
    @(negedge clk);
    check("rd_c3_wl", 32'(wl), 32'h0020);
    @(negedge clk);
    check("rd_c4_valid", 32'(rsp_valid), 1);
    check("rd_c4_wl", 32'(wl), 0);
    check("rd_c4_pre", 32'(pre), 0);
    pop1("rd");

    // Backpressure: bitlines move while the response is stalled
    idle_bl = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp%0d_valid", i), 32'(rsp_valid), 1);
      check($sformatf("bp%0d_data", i), 32'(rsp_data), 32'hA5);
      check($sformatf("bp%0d_req_ready", i), 32'(req_ready), 0);
      check($sformatf("bp%0d_wl", i), 32'(wl), 0);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release_req_ready", 32'(req_ready), 1);
    @(negedge clk);
    check("bp_done_valid", 32'(rsp_valid), 0);
    check("bp_idle_req_ready", 32'(req_ready), 1);

    // Back-to-back: row 0 then row 15, second request waits in RESP
    accept1(4'd0);
    req_addr  = 4'd15;
    req_valid = 1'b1;
    #1;
    check("b2b_c0_req_ready", 32'(req_ready), 0);
    @(negedge clk);
    @(negedge clk);
    check("b2b_c2_wl_latched", 32'(wl), 32'h0001);
    @(negedge clk);
    @(negedge clk);
    check("b2b_first_valid", 32'(rsp_valid), 1);
    pop1("b2b1");
    check("b2b_overlap_req_ready", 32'(req_ready), 1);
    sb1.push_back({1'b0, mem[15]});
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b_pre_no_idle", 32'(pre), 1);
    check("b2b_valid_dropped", 32'(rsp_valid), 0);
    @(negedge clk);
    @(negedge clk);
    check("b2b_c2_wl", 32'(wl), 32'h8000);
    wait_rsp1("b2b2", 2, 4);
    pop1("b2b2");
    @(negedge clk);

    // Sense error on row 9
    force_err = 1'b1;
    accept1(4'd9);
    wait_rsp1("err", 0, 4);
    pop1("err");
    @(negedge clk);
    force_err = 1'b0;

    // Reset during SEL discards the read
    accept1(4'd2);
    @(negedge clk);
    @(negedge clk);
    check("rmid_sel_wl", 32'(wl), 32'h0004);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check("rmid_wl", 32'(wl), 0);
    check("rmid_pre", 32'(pre), 0);
    check("rmid_valid", 32'(rsp_valid), 0);
    check("rmid_req_ready", 32'(req_ready), 1);
    sb1.delete();
    rst_n = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid) saw = 1'b1;
    end
    check("rmid_no_rsp", 32'(saw), 0);

    // PRE_CYC=1, WL_CYC=3 instance, row 3
    accept2(4'd3);
    check("sw_c0_pre", 32'(pre2), 1);
    check("sw_c0_wl", 32'(wl2), 0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check($sformatf("sw_c%0d_pre", c), 32'(pre2), 0);
      check($sformatf("sw_c%0d_wl", c), 32'(wl2), 32'h0008);
      check($sformatf("sw_c%0d_valid", c), 32'(rsp_valid2), 0);
    end
    @(negedge clk);
    check("sw_c4_valid", 32'(rsp_valid2), 1);
    check("sw_c4_wl", 32'(wl2), 0);
    pop2("sw");
    rsp_ready2 = 1'b1;
    @(negedge clk);
    check("sw_done_valid", 32'(rsp_valid2), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_read_seq.md
# sram_read_seq

Read sequencer for the SRAM macro: accepts a row address over a valid/ready request channel and drives precharge and the one-hot wordline. It senses the differential bitline pairs of the selected `sram_cell` row and returns the word over a valid/ready response channel. It sits between the memory controller and the cell array, opposite the write path that drives `bl`/`blb` as a true/complement pair.

## Interface
- `WIDTH`, 8: bits per word (bitline pairs).
- `ADDR_W`, 4: row address width; `ROWS = 2**ADDR_W` (localparam).
- `PRE_CYC`, 2: precharge cycles, legal range ≥1.
- `WL_CYC`, 2: wordline settle cycles before sampling, legal range ≥1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req_valid`  in  1  read request.
- `req_ready`  out  1  request accepted when `req_valid && req_ready`.
- `req_addr`  in  ADDR_W  row to read.
- `pre`  out  1  bitline precharge enable.
- `wl`  out  ROWS  one-hot wordline, all-zero when not selecting.
- `bl`  in  WIDTH  true bitlines.
- `blb`  in  WIDTH  complement bitlines.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumed when `rsp_valid && rsp_ready`.
- `rsp_data`  out  WIDTH  sensed word.
- `rsp_err`  out  1  sense error flag, valid with `rsp_valid`.

## Operation
- States:
  - IDLE → PRE on request accept; address is latched.
  - PRE holds PRE_CYC cycles → SEL.
  - SEL holds WL_CYC cycles → RESP.
  - RESP holds until response handshake → IDLE, or → PRE if a new request is accepted in the same cycle.
- `req_ready` = (state==IDLE) || (state==RESP && rsp_ready).
- `pre` = 1 only in PRE. `wl[addr]` = 1 only in SEL. `pre` and `wl` are never both asserted.
- Sampling happens on the edge ending the last SEL cycle:
  - `rsp_data[i] <= bl[i]`.
  - `rsp_err <= |(bl ~^ blb)`, i.e. any pair non-differential.
- `rsp_data`/`rsp_err` are held stable while `rsp_valid && !rsp_ready`.
- The internal down-counter reloads on each state entry. Its width is clog2(max(PRE_CYC,WL_CYC))+1.
- `req_addr` changes after accept have no effect; the latched address drives `wl`.

## Timing
- Reset (`rst_n`=0 at a rising edge):
  - State → IDLE.
  - `pre`=0, `wl`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, counter=0.
  - Applies mid-operation: any in-flight read is discarded with no response.
- All outputs are registered, except `req_ready` (combinational from state and `rsp_ready`).
- Latency: the accept edge is cycle 0. `rsp_valid`=1 from cycle PRE_CYC+WL_CYC (default 4).
- Back-to-back throughput: one read per PRE_CYC+WL_CYC cycles when `rsp_ready` is held high.
- Simultaneous response handshake and new request in RESP: the new request is accepted and `pre` rises the next cycle, with no IDLE cycle.

## Configuration
- `SRAM_READ_CHECK_EN` defined: `rsp_err` is computed as above.
- Undefined: `rsp_err` is tied 0, the comparison logic is removed, and `blb` is unused. Data path and timing are unchanged.

## Structure
- Package `sram_pkg`:
  - State enum `sram_rd_state_e` (IDLE, PRE, SEL, RESP).
  - Default parameter constants.
- Sub-module `sram_wl_decoder`: ADDR_W→ROWS one-hot decoder with enable, output all-zero when disabled. It is instantiated once, enabled in SEL.

## Test plan
- Reset mid-read: assert `rst_n`=0 during SEL → next cycle `wl`=0, `pre`=0, `rsp_valid`=0, `req_ready`=1; no response is ever produced.
- Single read, defaults, `req_addr`=5, array model drives bl=8'hA5, blb=8'h5A → `pre` high 2 cycles, then `wl`=16'h0020 for 2 cycles. `rsp_valid` high at cycle 4 with `rsp_data`=8'hA5, `rsp_err`=0.
- Backpressure: `rsp_ready`=0 for 5 cycles, with `bl` changed to 8'hFF during the stall → `rsp_data` stays 8'hA5, `req_ready`=0, `wl`=0 throughout.
- Back-to-back: `rsp_ready`=1, requests to addr 0 then 15 → second `pre` rises the cycle after the first response handshake; `wl`=16'h8000 for the second read; responses are 4 cycles apart.
- Sense error (SRAM_READ_CHECK_EN): bl=8'h01, blb=8'h01 → `rsp_err`=1, `rsp_data`=8'h01. Without the macro → `rsp_err`=0.
- Parameter sweep PRE_CYC=1, WL_CYC=3, addr 3 → `pre` high 1 cycle, `wl`=16'h0008 for 3 cycles, response at cycle 4; `pre`&|`wl` is never 1 (assertion).
